ks_multiword_adder: RTL

- Sequential multi-precision adder built around the team's parameterised Kogge-Stone adder, KoggeStone_par.
- Adds two WORDS*N-bit operands one N-bit word per cycle, least-significant word first, using a single KoggeStone_par #(.N(N)) instance.
- Carry is registered between words.
- Sits directly upstream of the adder: it feeds KoggeStone_par word slices and carry-in, then consumes its Sum/Cout into a result register.
- Valid/ready handshakes are used on both the operand side and the result side.

---
 rtl/ks_multiword_adder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ks_multiword_adder.sv
// ks_multiword_adder: sequential WORDS*N-bit adder, one N-bit word per cycle through KoggeStone_par.
// Optional macro KS_MW_OVF_EN adds the signed-overflow output ovf.
`default_nettype none

module KoggeStone_par #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  localparam int LV = (N > 1) ? $clog2(N) : 0;

  logic [N-1:0] w_gen [0:LV];
  logic [N-1:0] w_prp [0:LV];
  logic [N:0]   w_c;

  assign w_gen[0] = A & B;
  assign w_prp[0] = A ^ B;

  for (genvar lv = 0; lv < LV; lv++) begin : g_level
    localparam int D = 1 << lv;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_comb
        assign w_gen[lv+1][i] = w_gen[lv][i] | (w_prp[lv][i] & w_gen[lv][i-D]);
        assign w_prp[lv+1][i] = w_prp[lv][i] & w_prp[lv][i-D];
      end else begin : g_pass
        assign w_gen[lv+1][i] = w_gen[lv][i];
        assign w_prp[lv+1][i] = w_prp[lv][i];
      end
    end
  end

  // Cin folds in after the prefix tree: each prefix group spans bits [i:0].
  assign w_c[0] = Cin;
  for (genvar i = 0; i < N; i++) begin : g_carry
    assign w_c[i+1] = w_gen[LV][i] | (w_prp[LV][i] & Cin);
  end

  assign Sum  = w_prp[0] ^ w_c[N-1:0];
  assign Cout = w_c[N];
endmodule

module ks_multiword_adder #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout
`ifdef KS_MW_OVF_EN
  ,
  output logic               ovf
`endif
);
  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [N-1:0]    w_ks_sum;
  logic            w_ks_cout;
  logic [W-1:0]    w_sum_next;

  KoggeStone_par #(.N(N)) u_ks (
    .A    (a_sh_q[N-1:0]),
    .B    (b_sh_q[N-1:0]),
    .Cin  (carry_q),
    .Sum  (w_ks_sum),
    .Cout (w_ks_cout)
  );

  if (WORDS == 1) begin : g_one_word
    assign w_sum_next = w_ks_sum;
  end else begin : g_multi_word
    assign w_sum_next = {w_ks_sum, sum_sh_q[W-1:N]};
  end

`ifdef KS_MW_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
`ifdef KS_MW_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_ADD;
`ifdef KS_MW_OVF_EN
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
`endif
        end
      end
      S_ADD: begin
        a_sh_d   = a_sh_q >> N;
        b_sh_d   = b_sh_q >> N;
        sum_sh_d = w_sum_next;
        carry_d  = w_ks_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = w_ks_cout;
          state_d = S_DONE;
`ifdef KS_MW_OVF_EN
          // Carry into the MSB is recovered from the top sum bit and the captured operand MSBs.
          ovf_d   = w_ks_sum[N-1] ^ a_msb_q ^ b_msb_q ^ w_ks_cout;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
`ifdef KS_MW_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
`ifdef KS_MW_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_sh_q;
  assign cout      = cout_q;
`ifdef KS_MW_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

`default_nettype wire
